// File: rtl/sensor_scan_ctrl.sv
// Time-multiplexed sensor bank scanner: selects a bank, waits for the mux to settle,
// samples a shared error function, debounces per bank and reports new faults by valid/ack.
module sensor_scan_ctrl #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned DEBOUNCE  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [3:0]                   sensors,
  output logic [$clog2(NUM_BANKS)-1:0] bank_sel,
  output logic                         fault_valid,
  output logic [$clog2(NUM_BANKS)-1:0] fault_bank,
  input  logic                         fault_ack,
  input  logic                         clear_flags,
  output logic [NUM_BANKS-1:0]         fault_flags,
  output logic                         scan_done
);

  localparam int unsigned BW = $clog2(NUM_BANKS);
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam int unsigned SW = $clog2(SETTLE + 1);

  localparam logic [BW-1:0] LastBank   = BW'(NUM_BANKS - 1);
  localparam logic [CW-1:0] DebMax     = CW'(DEBOUNCE);
  localparam logic [CW:0]   DebTarget  = (CW + 1)'(DEBOUNCE);
  localparam logic [SW-1:0] SettleLast = SW'(SETTLE - 1);

  typedef enum logic [2:0] {StIdle, StSettle, StSample, StReport, StNext} state_e;

  state_e        state_q;
  logic [SW-1:0] settle_q;
  logic [CW-1:0] cnt_q [NUM_BANKS];

  logic          err;
  logic [CW-1:0] cur_cnt;
  logic [CW:0]   cnt_inc;
  logic          hit;

  always_comb begin
    err     = sensors[0] | (sensors[1] & (sensors[3] | sensors[2]));
    cur_cnt = cnt_q[bank_sel];
    cnt_inc = {1'b0, cur_cnt} + (CW + 1)'(1);
    // A saturated counter never "reaches" DEBOUNCE again, so a held fault reports once.
    hit     = err && (cnt_inc == DebTarget) && !fault_flags[bank_sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      settle_q    <= '0;
      bank_sel    <= '0;
      fault_valid <= 1'b0;
      fault_bank  <= '0;
      fault_flags <= '0;
      scan_done   <= 1'b0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) cnt_q[i] <= '0;
    end else begin
      scan_done <= 1'b0;
      if (clear_flags) begin
        fault_flags <= '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) cnt_q[i] <= '0;
      end

      case (state_q)
        StIdle: begin
          if (enable) begin
            settle_q <= '0;
            state_q  <= StSettle;
          end
        end
        StSettle: begin
          settle_q <= settle_q + SW'(1);
          if (settle_q == SettleLast) state_q <= StSample;
        end
        StSample: begin
          state_q <= StNext;
          // A coincident clear wins over the sample: counters stay cleared, no flag is set.
          if (!clear_flags) begin
            if (err) cnt_q[bank_sel] <= (cur_cnt == DebMax) ? DebMax : cur_cnt + CW'(1);
            else     cnt_q[bank_sel] <= '0;
            if (hit) begin
              fault_flags[bank_sel] <= 1'b1;
              fault_bank            <= bank_sel;
              fault_valid           <= 1'b1;
              state_q               <= StReport;
            end
          end
        end
        StReport: begin
          if (fault_ack) begin
            fault_valid <= 1'b0;
            state_q     <= StNext;
          end
        end
        StNext: begin
          bank_sel  <= (bank_sel == LastBank) ? '0 : bank_sel + BW'(1);
          scan_done <= (bank_sel == LastBank);
          settle_q  <= '0;
          state_q   <= enable ? StSettle : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Directed bench for sensor_scan_ctrl: a per-cycle vector table for the idle scan,
// then hand-timed sequences for debounce, handshake, clear and reset/enable corners.
module tb_sensor_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable, fault_ack, clear_flags;
  logic [3:0] sensors;
  logic [1:0] bank_sel, fault_bank;
  logic       fault_valid, scan_done;
  logic [3:0] fault_flags;

  // External mux model: each bank presents its own 4-bit value.
  logic [3:0] bank_val [4];
  assign sensors = bank_val[bank_sel];

  sensor_scan_ctrl #(.NUM_BANKS(4), .SETTLE(2), .DEBOUNCE(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sensors    (sensors),
    .bank_sel   (bank_sel),
    .fault_valid(fault_valid),
    .fault_bank (fault_bank),
    .fault_ack  (fault_ack),
    .clear_flags(clear_flags),
    .fault_flags(fault_flags),
    .scan_done  (scan_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, ack, clr;
    logic [1:0] bank;
    logic       sd, fv;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs [20];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Advance until the cycle right after a bank_sel wrap (scan_done high).
  task automatic sync_scan();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (scan_done === 1'b1) found = 1'b1;
    end
    check("sync_scan_done", {31'd0, found}, 32'd1);
  endtask

  // Step n cycles, returning 1 if fault_valid was seen high on any of them.
  task automatic run_watch(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (fault_valid !== 1'b0) seen = 1'b1;
    end
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
  endtask

  task automatic do_ack();
    fault_ack = 1'b1;
    step();
    fault_ack = 1'b0;
  endtask

  function automatic vec_t mk(logic r, logic e, logic a, logic c, logic [1:0] b, logic sd,
                              logic fv, logic [3:0] fl);
    vec_t v;
    v.rst = r; v.en = e; v.ack = a; v.clr = c;
    v.bank = b; v.sd = sd; v.fv = fv; v.flags = fl;
    return v;
  endfunction

  logic seen, ok;

  initial begin
    rst = 1'b1; enable = 1'b0; fault_ack = 1'b0; clear_flags = 1'b0;
    for (int i = 0; i < 4; i++) bank_val[i] = 4'b0000;

    // Idle scan: 4 cycles per bank, wrap pulse 16 cycles after the first bank starts.
    // Stray ack/clear while nothing is pending must have no effect.
    vecs[0]  = mk(1, 0, 0, 0, 2'd0, 0, 0, 4'h0);
    vecs[1]  = mk(0, 1, 0, 0, 2'd0, 0, 0, 4'h0);
    vecs[2]  = mk(0, 1, 1, 0, 2'd0, 0, 0, 4'h0);
    vecs[3]  = mk(0, 1, 1, 0, 2'd0, 0, 0, 4'h0);
    vecs[4]  = mk(0, 1, 0, 0, 2'd0, 0, 0, 4'h0);
    vecs[5]  = mk(0, 1, 0, 0, 2'd1, 0, 0, 4'h0);
    vecs[6]  = mk(0, 1, 0, 1, 2'd1, 0, 0, 4'h0);
    vecs[7]  = mk(0, 1, 0, 0, 2'd1, 0, 0, 4'h0);
    vecs[8]  = mk(0, 1, 0, 0, 2'd1, 0, 0, 4'h0);
    vecs[9]  = mk(0, 1, 0, 0, 2'd2, 0, 0, 4'h0);
    vecs[10] = mk(0, 1, 0, 0, 2'd2, 0, 0, 4'h0);
    vecs[11] = mk(0, 1, 0, 0, 2'd2, 0, 0, 4'h0);
    vecs[12] = mk(0, 1, 0, 0, 2'd2, 0, 0, 4'h0);
    vecs[13] = mk(0, 1, 0, 0, 2'd3, 0, 0, 4'h0);
    vecs[14] = mk(0, 1, 0, 0, 2'd3, 0, 0, 4'h0);
    vecs[15] = mk(0, 1, 1, 0, 2'd3, 0, 0, 4'h0);
    vecs[16] = mk(0, 1, 0, 0, 2'd3, 0, 0, 4'h0);
    vecs[17] = mk(0, 1, 0, 0, 2'd0, 1, 0, 4'h0);
    vecs[18] = mk(0, 1, 0, 0, 2'd0, 0, 0, 4'h0);
    vecs[19] = mk(0, 1, 0, 0, 2'd0, 0, 0, 4'h0);

    for (int k = 0; k < 20; k++) begin
      rst = vecs[k].rst; enable = vecs[k].en; fault_ack = vecs[k].ack;
      clear_flags = vecs[k].clr;
      step();
      check($sformatf("v%0d_bank_sel", k), 32'(bank_sel), 32'(vecs[k].bank));
      check($sformatf("v%0d_scan_done", k), 32'(scan_done), 32'(vecs[k].sd));
      check($sformatf("v%0d_fault_valid", k), 32'(fault_valid), 32'(vecs[k].fv));
      check($sformatf("v%0d_fault_flags", k), 32'(fault_flags), 32'(vecs[k].flags));
    end
    fault_ack = 1'b0; clear_flags = 1'b0;

    // Error truth table on bank 1 (bank 1 samples at wrap+7, +23, +39).
    sync_scan();
    bank_val[1] = 4'b1100;
    run_watch(48, seen);
    check("tt1100_no_report", 32'(seen), 32'd0);
    check("tt1100_flags", 32'(fault_flags), 32'h0);
    check("scan_period_16", 32'(scan_done), 32'd1);
    bank_val[1] = 4'b0110;
    run_watch(38, seen);
    check("tt0110_early", 32'(seen), 32'd0);
    step();
    check("tt0110_valid", 32'(fault_valid), 32'd1);
    check("tt0110_bank", 32'(fault_bank), 32'd1);
    check("tt0110_flags", 32'(fault_flags), 32'h2);
    do_ack();
    check("tt0110_ack_drop", 32'(fault_valid), 32'd0);
    pulse_clear();
    check("tt_clear_flags", 32'(fault_flags), 32'h0);
    bank_val[1] = 4'b0001;
    sync_scan();
    run_watch(38, seen);
    check("tt0001_early", 32'(seen), 32'd0);
    step();
    check("tt0001_valid", 32'(fault_valid), 32'd1);
    check("tt0001_bank", 32'(fault_bank), 32'd1);
    bank_val[1] = 4'b0000;
    do_ack();

    // Debounce break on bank 2: err, err, clean, err, err, err.
    pulse_clear();
    sync_scan();
    bank_val[2] = 4'b0001;
    run_watch(32, seen);
    bank_val[2] = 4'b0000;
    run_watch(16, ok);
    seen = seen | ok;
    bank_val[2] = 4'b0001;
    run_watch(42, ok);
    seen = seen | ok;
    check("deb_break_early", 32'(seen), 32'd0);
    step();
    check("deb_break_valid", 32'(fault_valid), 32'd1);
    check("deb_break_bank", 32'(fault_bank), 32'd2);
    check("deb_break_flags", 32'(fault_flags), 32'h4);
    bank_val[2] = 4'b0000;
    do_ack();

    // Handshake stall on bank 0.
    sync_scan();
    bank_val[0] = 4'b0001;
    run_watch(34, seen);
    check("stall_early", 32'(seen), 32'd0);
    step();
    check("stall_valid", 32'(fault_valid), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fault_valid !== 1'b1 || fault_bank !== 2'd0 || bank_sel !== 2'd0) ok = 1'b0;
    end
    check("stall_stable", 32'(ok), 32'd1);
    bank_val[0] = 4'b0000;
    do_ack();
    check("stall_ack_valid", 32'(fault_valid), 32'd0);
    check("stall_ack_bank_sel", 32'(bank_sel), 32'd0);
    step();
    check("stall_resume_bank1", 32'(bank_sel), 32'd1);
    check("stall_flags", 32'(fault_flags), 32'h5);

    // Persistent fault on bank 3: one report, none while flagged, re-report after clear.
    pulse_clear();
    sync_scan();
    bank_val[3] = 4'b0001;
    run_watch(46, seen);
    check("b3_early", 32'(seen), 32'd0);
    step();
    check("b3_valid", 32'(fault_valid), 32'd1);
    check("b3_bank", 32'(fault_bank), 32'd3);
    do_ack();
    sync_scan();
    run_watch(48, seen);
    check("b3_no_rereport", 32'(seen), 32'd0);
    check("b3_flag_held", 32'(fault_flags), 32'h8);
    run_watch(14, seen);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("b3_clear_in_sample_flags", 32'(fault_flags), 32'h0);
    check("b3_clear_in_sample_valid", 32'(fault_valid), 32'd0);
    seen = 1'b0;
    for (int i = 1; i <= 47; i++) begin
      step();
      if (i == 1) check("b3_clear_then_wrap", {30'd0, bank_sel, scan_done}, 32'd1);
      if (fault_valid !== 1'b0) seen = 1'b1;
    end
    check("b3_rereport_early", 32'(seen), 32'd0);
    step();
    check("b3_rereport_valid", 32'(fault_valid), 32'd1);
    check("b3_rereport_bank", 32'(fault_bank), 32'd3);

    // Reset while in REPORT, then hold idle.
    rst = 1'b1; enable = 1'b0;
    step();
    rst = 1'b0;
    bank_val[3] = 4'b0000;
    check("rst_valid", 32'(fault_valid), 32'd0);
    check("rst_bank_sel", 32'(bank_sel), 32'd0);
    check("rst_flags", 32'(fault_flags), 32'h0);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bank_sel !== 2'd0 || fault_valid !== 1'b0 || scan_done !== 1'b0) ok = 1'b0;
    end
    check("rst_idle_hold", 32'(ok), 32'd1);

    // Drop enable during bank-2 SETTLE on the third pass: bank 2 still samples and reports.
    enable = 1'b1;
    bank_val[2] = 4'b0001;
    step();
    run_watch(40, seen);
    check("en_drop_early", 32'(seen), 32'd0);
    check("en_drop_at_bank2", 32'(bank_sel), 32'd2);
    enable = 1'b0;
    run_watch(2, seen);
    check("en_drop_settle_quiet", 32'(seen), 32'd0);
    step();
    check("en_drop_valid", 32'(fault_valid), 32'd1);
    check("en_drop_bank", 32'(fault_bank), 32'd2);
    step();
    check("en_drop_report_held", 32'(fault_valid), 32'd1);
    do_ack();
    check("en_drop_ack", 32'(fault_valid), 32'd0);
    bank_val[2] = 4'b0000;
    step();
    check("en_drop_bank_sel3", 32'(bank_sel), 32'd3);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bank_sel !== 2'd3 || fault_valid !== 1'b0 || scan_done !== 1'b0) ok = 1'b0;
    end
    check("en_drop_idle", 32'(ok), 32'd1);
    check("en_drop_flags", 32'(fault_flags), 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
